// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared datapath constants and types for the register file.
//               The decoder and the ALU also use these constants and types.
//               RF_DATA_W - register / data-port width
//               RF_DEPTH  - number of registers
//               RF_ADDR_W - address width, equal to clog2(RF_DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    localparam int RF_DATA_W = 4;
    localparam int RF_DEPTH  = 8;
    localparam int RF_ADDR_W = 3;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : DEPTH x DATA_W register file. It has two combinational read
//               ports and one synchronous write port. Every entry, including
//               address 0, is a normal read/write register. There is no
//               write-to-read bypass.
// Ports       : RF_d1 / RF_d2   - read data for ports 1 and 2 (combinational)
//               RF_ad1 / RF_ad2 - read addresses for ports 1 and 2
//               RF_wa           - write address
//               RF_we           - write enable, active high
//               RF_wd           - write data
//               clk             - rising-edge clock for writes
//               rst             - asynchronous active-low reset; it clears
//                                 all registers
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    output logic [DATA_W-1:0] RF_d1,
    output logic [DATA_W-1:0] RF_d2,
    input  logic [ADDR_W-1:0] RF_ad1,
    input  logic [ADDR_W-1:0] RF_ad2,
    input  logic [ADDR_W-1:0] RF_wa,
    input  logic              RF_we,
    input  logic [DATA_W-1:0] RF_wd,
    input  logic              clk,
    input  logic              rst
);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  w_wr_sel;

    // One-hot write decode. At most one entry is selected, and only when
    // RF_we is high.
    always_comb begin
        w_wr_sel = '0;
        if (RF_we) begin
            w_wr_sel[RF_wa] = 1'b1;
        end
    end

    // Each entry has its own flop group. The reset is asynchronous, so while
    // rst is low the reads return 0 with no clock edge. A write that shares
    // an edge with an active reset is dropped.
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_regs[g] <= '0;
            end else if (w_wr_sel[g]) begin
                r_regs[g] <= RF_wd;
            end
        end
    end

    // The read muxes see only stored state. A same-cycle write to the address
    // being read shows up only after the edge.
    assign RF_d1 = r_regs[RF_ad1];
    assign RF_d2 = r_regs[RF_ad2];

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file. A plain array models
//               the register contents. Directed steps come first, followed by
//               a block of random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;
    import register_file_pkg::*;

    logic       clk    = 1'b0;
    bit         clk_en = 1'b0;
    logic       rst    = 1'b1;
    rf_data_t   RF_d1, RF_d2;
    rf_addr_t   RF_ad1 = '0, RF_ad2 = '0, RF_wa = '0;
    logic       RF_we  = 1'b0;
    rf_data_t   RF_wd  = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    rf_data_t model [RF_DEPTH];

    register_file dut (
        .RF_d1 (RF_d1),
        .RF_d2 (RF_d2),
        .RF_ad1(RF_ad1),
        .RF_ad2(RF_ad2),
        .RF_wa (RF_wa),
        .RF_we (RF_we),
        .RF_wd (RF_wd),
        .clk   (clk),
        .rst   (rst)
    );

    // The clock toggles only while clk_en is set, so the reset checks can run
    // with no clock edge at all.
    always begin
        #10;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input rf_data_t obs, input rf_data_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step one clock edge, then update the model the way the specification
    // describes it.
    task automatic tick();
        @(posedge clk);
        if (rst && RF_we) model[RF_wa] = RF_wd;
        if (!rst) foreach (model[k]) model[k] = '0;
        #2;
    endtask

    task automatic wr(input int a, input rf_data_t d);
        RF_wa = rf_addr_t'(a);
        RF_wd = d;
        RF_we = 1'b1;
        tick();
        RF_we = 1'b0;
    endtask

    task automatic rd(input string tag, input int a1, input int a2);
        RF_ad1 = rf_addr_t'(a1);
        RF_ad2 = rf_addr_t'(a2);
        #1;
        chk({tag, "_d1"}, RF_d1, model[a1]);
        chk({tag, "_d2"}, RF_d2, model[a2]);
    endtask

    initial begin
        foreach (model[k]) model[k] = '0;

        // Reset with no clock: every address must read 0.
        #3;
        rst = 1'b0;
        #1;
        for (int i = 0; i < RF_DEPTH; i++) begin
            RF_ad1 = rf_addr_t'(i);
            RF_ad2 = rf_addr_t'($urandom_range(RF_DEPTH - 1));
            #1;
            chk("reset_d1", RF_d1, 4'h0);
            chk("reset_d2", RF_d2, 4'h0);
        end

        // Start the clock, then release reset between edges.
        clk_en = 1'b1;
        #25;
        rst = 1'b1;
        @(negedge clk);

        // Fill the registers with ascending values.
        for (int i = 0; i < RF_DEPTH; i++) wr(i, rf_data_t'(i));
        for (int i = 0; i < RF_DEPTH - 1; i++) begin
            rd("asc", i, i + 1);
            chk("asc_const", RF_d1, rf_data_t'(i));
        end

        // Fill the registers with negative values (two's complement patterns).
        for (int i = 0; i < RF_DEPTH; i++) wr(i, rf_data_t'(16 - i));
        for (int i = 0; i < RF_DEPTH - 1; i++) rd("neg", i, i + 1);
        rd("neg34", 3, 4);
        chk("neg34_d1_const", RF_d1, 4'hD);
        chk("neg34_d2_const", RF_d2, 4'hC);

        // With the write enable low, the write inputs must be ignored.
        RF_we = 1'b0;
        RF_wa = 3'd5;
        RF_wd = 4'hA;
        repeat (3) tick();
        rd("we_gate", 5, 5);
        chk("we_gate_const", RF_d1, 4'hB);

        // Read during write: the old value is returned before the edge and
        // the new value after it.
        wr(2, 4'h2);
        RF_ad1 = 3'd2;
        RF_ad2 = 3'd2;
        RF_wa  = 3'd2;
        RF_wd  = 4'h7;
        RF_we  = 1'b1;
        #1;
        chk("rdw_before", RF_d1, 4'h2);
        chk("rdw_same_port", RF_d2, RF_d1);
        tick();
        RF_we = 1'b0;
        chk("rdw_after_d1", RF_d1, 4'h7);
        chk("rdw_after_d2", RF_d2, 4'h7);

        // Random traffic: each cycle the reads are checked against the model
        // before the edge, and the writes land on the edge.
        for (int n = 0; n < 200; n++) begin
            RF_we  = 1'($urandom_range(1));
            RF_wa  = rf_addr_t'($urandom_range(RF_DEPTH - 1));
            RF_wd  = rf_data_t'($urandom_range(15));
            RF_ad1 = rf_addr_t'($urandom_range(RF_DEPTH - 1));
            RF_ad2 = ($urandom_range(3) == 0) ? RF_ad1 : rf_addr_t'($urandom_range(RF_DEPTH - 1));
            #1;
            chk("rand_d1", RF_d1, model[RF_ad1]);
            chk("rand_d2", RF_d2, model[RF_ad2]);
            tick();
        end
        RF_we = 1'b0;

        // Make sure the contents are nonzero, so the clear can be seen.
        for (int i = 0; i < RF_DEPTH; i++) wr(i, rf_data_t'(i + 8));

        // Assert reset between edges: the reads go to 0 at once.
        #2;
        rst = 1'b0;
        foreach (model[k]) model[k] = '0;
        for (int i = 0; i < RF_DEPTH; i++) begin
            RF_ad1 = rf_addr_t'(i);
            RF_ad2 = rf_addr_t'(RF_DEPTH - 1 - i);
            #1;
            chk("midrst_d1", RF_d1, 4'h0);
            chk("midrst_d2", RF_d2, 4'h0);
        end
        // A write held across an edge during reset must be discarded.
        RF_wa = 3'd1;
        RF_wd = 4'hF;
        RF_we = 1'b1;
        tick();
        RF_we = 1'b0;
        rd("rst_write_drop", 1, 1);
        chk("rst_write_drop_const", RF_d1, 4'h0);

        // Release reset, then write address 6. Every other entry stays 0.
        @(negedge clk);
        rst = 1'b1;
        #2;
        wr(6, 4'h3);
        for (int i = 0; i < RF_DEPTH; i++) begin
            rd("post_rst", i, 6);
            chk("post_rst_const", RF_d1, (i == 6) ? 4'h3 : 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire

// File: doc/register_file.md
# register_file

Eight-entry, 4-bit-wide register file for the simple microprocessor datapath. It provides two independent combinational read ports and one synchronous write port. It sits between the instruction decoder, which supplies the addresses, and the ALU, which consumes the operands and produces the write-back data.

## Interface
Parameters:
- DATA_W, 4, width of each register and of the data ports.
- DEPTH, 8, number of registers.
- ADDR_W, 3, address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock; all writes occur on its rising edge.
- rst  in  1  reset, asynchronous and active-low; clears every register to 0.
- RF_d1  out  DATA_W  read data, port 1.
- RF_d2  out  DATA_W  read data, port 2.
- RF_ad1  in  ADDR_W  read address, port 1.
- RF_ad2  in  ADDR_W  read address, port 2.
- RF_wa  in  ADDR_W  write address.
- RF_we  in  1  write enable, active-high.
- RF_wd  in  DATA_W  write data.

Declared positional port order is fixed for existing instantiations: RF_d1, RF_d2, RF_ad1, RF_ad2, RF_wa, RF_we, RF_wd, clk, rst.

## Operation
- Storage is DEPTH registers of DATA_W bits, addressed 0..DEPTH-1.
- All entries, including address 0, are ordinary read/write registers; there is no hardwired zero.
- Write: on a rising clk edge with rst high and RF_we=1, register[RF_wa] takes the value of RF_wd. All other registers hold.
- With RF_we=0, no register changes. RF_wa and RF_wd are don't-care.
- Read: RF_d1 = register[RF_ad1] and RF_d2 = register[RF_ad2], purely combinationally.
- Both ports may address the same register and then return identical data.
- Data is an opaque bit pattern with no arithmetic. For example, -3 written as 4'b1101 reads back as 4'b1101.
- Reset: while rst is low, every register is forced to 0. Both outputs therefore read 0 for any address. Writes are ignored during reset.

## Timing
- Write latency: the new value becomes visible on a read port matching RF_wa immediately after the rising edge that performs the write, within the same cycle's combinational settle.
- Read latency: zero cycles. The outputs follow address changes combinationally.
- Read-during-write to the same address, before the edge: the port returns the old stored value. There is no write-to-read bypass.
- Reset assertion takes effect immediately, independent of clk. All outputs read 0 without waiting for an edge.
- Reset deassertion: the first write can occur on the first rising edge after rst goes high.
- Reset asserted mid-operation: any write pending at that edge is discarded and all contents are lost.
- Address values are always in range because DEPTH = 2^ADDR_W, so there is no out-of-range behaviour.

## Structure
- Shared package (datapath package) holds the RF_DATA_W=4, RF_DEPTH=8 and RF_ADDR_W=3 constants, plus the typedefs rf_data_t (logic [3:0]) and rf_addr_t (logic [2:0]). The decoder and ALU share these.
- Single flat module with no sub-modules:
  - storage array with an always_ff block (async reset, sync write);
  - two continuous-assign read muxes.
- A one-hot write-decode helper is permitted inline and does not need a separate module.

## Test plan
- Reset: drive rst=0 with random addresses -> RF_d1 = RF_d2 = 0 for all 8 addresses, with no clock edge required.
- Fill ascending: after reset release, with RF_we=1, write value i to address i for i=0..7, one per cycle. Then with RF_we=0, read (ad1,ad2) = (i,i+1) for i=0..6 -> d1 = i, d2 = i+1.
- Fill negative: write -i (4-bit two's complement; 0, F, E, D, C, B, A, 9) to address i. Then read (i,i+1) -> d1 = (-i) mod 16, d2 = (-(i+1)) mod 16. For example, ad1=3, ad2=4 gives d1=4'hD, d2=4'hC.
- Write-enable gating: with RF_we=0, present RF_wa=5 and RF_wd=4'hA for several edges -> register 5 is unchanged.
- Read-during-write: with ad1=RF_wa=2, register 2=4'h2, RF_wd=4'h7, RF_we=1 -> d1=2 before the edge and d1=7 after it. Also read with ad1=ad2 -> both ports return the same value.
- Async reset mid-run: pull rst low between clock edges after the fill -> all reads return 0 immediately. After release, a write to address 6 of 4'h3 -> reading 6 gives 3 and every other address gives 0.
